serial_adder: RTL and testbench
===============================

// Module: serial_adder
// PURPOSE
//   Bit-serial adder: adds two WIDTH-bit operands plus carry-in, one bit per clock, LSB first.
//   It uses a single full-adder cell (sum = a^b^c, carry = majority(a,b,c)) and a registered carry.
//   It is the sequential consumer of the full-adder cell and trades latency for one-cell area.
//   The start/busy/done handshake lets a controller or test fixture drive it directly.
// PARAMETERS
//   WIDTH   8   operand and result width in bits (legal range 2..32)
// PORTS
//   clk      in   1      single clock; all state changes on its rising edge
//   rst      in   1      synchronous, active-high reset
//   start    in   1      request a new addition; sampled only when accepted (see BEHAVIOUR)
//   a_in     in   WIDTH  operand A; captured on the accepted start
//   b_in     in   WIDTH  operand B; captured on the accepted start
//   cin      in   1      carry-in; captured on the accepted start
//   busy     out  1      high while a serial addition is in progress
//   done     out  1      one-cycle pulse: sum_out/cout newly valid
//   sum_out  out  WIDTH  result (a_in + b_in + cin) mod 2^WIDTH; held until the next done
//   cout     out  1      carry out of bit WIDTH-1; held with sum_out
// BEHAVIOUR
//   Reset: rst=1 at a clock edge puts the FSM in IDLE and clears every register.
//     Outputs after reset: busy=0, done=0, sum_out=0, cout=0.
//     Reset wins over every other input, including mid-operation; a partial result is discarded.
//   FSM states: IDLE, RUN, DONE.
//     IDLE -> RUN  on start=1.
//     RUN  -> RUN  while bit count < WIDTH-1.
//     RUN  -> DONE when bit WIDTH-1 is processed.
//     DONE -> RUN  on start=1 (back-to-back operations).
//     DONE -> IDLE on start=0.
//   Accept: start is accepted only in IDLE or DONE. start in RUN is ignored (not queued).
//   On accept:
//     - Load shift registers A<=a_in, B<=b_in; carry reg <= cin; bit count <= 0.
//     - busy=1 from the next cycle.
//   Each RUN cycle:
//     - Compute s = A[0]^B[0]^c and c' = maj(A[0],B[0],c).
//     - Shift A and B right by 1.
//     - Shift s into the MSB of the internal sum shift register; carry reg <= c'; count++.
//   Entering DONE:
//     - sum_out <= completed sum register; cout <= final carry.
//     - busy=0 and done=1 for exactly that one cycle.
//   Latency: start accepted at edge T -> done high in the cycle after edge T+WIDTH.
//     Total: WIDTH+1 cycles from start to done; throughput one result per WIDTH+1 cycles.
//   sum_out and cout change only when entering DONE, or on reset; they are stable otherwise.
//   Operand inputs may change freely after the accepting edge.
//   Wrap-around: all-ones + 1 gives sum_out=0, cout=1. No other overflow flag exists.
//   busy and done are never high together.
// TESTING (WIDTH=8 unless stated; T = accepting edge)
//   1. a=0x00, b=0x00, cin=0, start pulse -> sum_out=0x00, cout=0; done pulse after T+8; busy high 8 cycles.
//   2. a=0xFF, b=0x01, cin=0 -> sum_out=0x00, cout=1 (full ripple and wrap-around).
//   3. a=0xA5, b=0x5A, cin=1 -> sum_out=0x00, cout=1.
//      Then a=0x3C, b=0x42, cin=0 with start held high in the DONE cycle -> back-to-back;
//      second result sum_out=0x7E, cout=0.
//   4. Start a=0x10, b=0x20; pulse start again at T+3 with a=0xFF
//      -> second start ignored; sum_out=0x30, cout=0; exactly one done pulse.
//   5. Start a=0x80, b=0x80; assert rst at T+4 -> next cycle busy=0, done=0, sum_out=0, cout=0.
//      No done pulse follows; a new start after reset completes normally.
//   6. WIDTH=3: all 128 combinations of (a, b, cin) -> {cout,sum_out} == a+b+cin for every case,
//      checked by a self-checking scoreboard.

Source files
------------

// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder, one full-adder cell, LSB first, start/busy/done handshake
//   clk      in   1      rising-edge clock
//   rst      in   1      synchronous active-high reset
//   start    in   1      request an addition; accepted in IDLE or DONE only
//   a_in     in   WIDTH  operand A, captured on accept
//   b_in     in   WIDTH  operand B, captured on accept
//   cin      in   1      carry-in, captured on accept
//   busy     out  1      addition in progress
//   done     out  1      one-cycle pulse when sum_out/cout update
//   sum_out  out  WIDTH  (a_in + b_in + cin) mod 2^WIDTH, held until next done
//   cout     out  1      carry out of bit WIDTH-1, held with sum_out
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum_out,
   output logic             cout
);
   localparam int CW = $clog2(WIDTH);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sh_q, sh_d, sum_q, sum_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             c_q, c_d, cout_q, cout_d, s, c_nxt, accept;
   always_comb begin
      s       = a_q[0] ^ b_q[0] ^ c_q;
      c_nxt   = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
      accept  = start && state_q != RUN;
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sh_d    = sh_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      c_d     = c_q;
      cout_d  = cout_q;
      if (accept) begin
         state_d = RUN;
         a_d     = a_in;
         b_d     = b_in;
         c_d     = cin;
         cnt_d   = '0;
      end else if (state_q == RUN) begin
         a_d   = a_q >> 1;
         b_d   = b_q >> 1;
         sh_d  = {s, sh_q[WIDTH-1:1]};
         c_d   = c_nxt;
         cnt_d = cnt_q + CW'(1);
         if (cnt_q == CW'(WIDTH - 1)) begin
            state_d = DONE;
            sum_d   = {s, sh_q[WIDTH-1:1]};
            cout_d  = c_nxt;
         end
      end else if (state_q == DONE) begin
         state_d = IDLE;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sh_q    <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         c_q     <= 1'b0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sh_q    <= sh_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         c_q     <= c_d;
         cout_q  <= cout_d;
      end
   end
   assign busy    = state_q == RUN;
   assign done    = state_q == DONE;
   assign sum_out = sum_q;
   assign cout    = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed and exhaustive checks of serial_adder at WIDTH=8 and WIDTH=3
module tb_serial_adder;
   logic       clk = 1'b0, rst = 1'b1, start8 = 1'b0, start3 = 1'b0, cin = 1'b0, sel = 1'b0;
   logic [7:0] a = '0, b = '0;
   logic       busy8, done8, cout8, busy3, done3, cout3;
   logic [7:0] sum8;
   logic [2:0] sum3;
   logic       done_s, busy_s;
   logic [8:0] res_s;
   logic [8:0] q[$];
   int         tests = 0, fails = 0;

   serial_adder #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst), .start(start8), .a_in(a), .b_in(b), .cin(cin),
      .busy(busy8), .done(done8), .sum_out(sum8), .cout(cout8)
   );
   serial_adder #(.WIDTH(3)) u_dut3 (
      .clk(clk), .rst(rst), .start(start3), .a_in(a[2:0]), .b_in(b[2:0]), .cin(cin),
      .busy(busy3), .done(done3), .sum_out(sum3), .cout(cout3)
   );

   always #5 clk = ~clk;

   assign done_s = sel ? done3 : done8;
   assign busy_s = sel ? busy3 : busy8;
   assign res_s  = sel ? {5'b0, cout3, sum3} : {cout8, sum8};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic launch(input logic [7:0] av, input logic [7:0] bv, input logic cv, input bit push);
      a   = av;
      b   = bv;
      cin = cv;
      if (sel) start3 = 1'b1;
      else start8 = 1'b1;
      if (push) q.push_back(sel ? 9'(av[2:0]) + 9'(bv[2:0]) + 9'(cv) : 9'(av) + 9'(bv) + 9'(cv));
      tick();
      start8 = 1'b0;
      start3 = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int lat, input int busy_exp);
      int k = 0, bn = 0;
      logic [8:0] e;
      while (!done_s && k < 40) begin
         if (busy_s) bn++;
         tick();
         k++;
      end
      check({tag, "_lat"}, k, lat);
      if (busy_exp >= 0) check({tag, "_busy_cycles"}, bn, busy_exp);
      if (done_s) begin
         check({tag, "_busy_at_done"}, {31'b0, busy_s}, 0);
         check({tag, "_queue"}, {31'b0, q.size() != 0}, 1);
         if (q.size() != 0) begin
            e = q.pop_front();
            check({tag, "_result"}, {23'b0, res_s}, {23'b0, e});
         end
      end
   endtask

   initial begin
      int pulses;
      tick();
      tick();
      check("reset_busy", {31'b0, busy8}, 0);
      check("reset_done", {31'b0, done8}, 0);
      check("reset_sum", {24'b0, sum8}, 0);
      check("reset_cout", {31'b0, cout8}, 0);
      rst = 1'b0;
      tick();
      launch(8'h00, 8'h00, 1'b0, 1);
      check("t1_busy_after_accept", {31'b0, busy8}, 1);
      wait_done("t1", 8, 8);
      tick();
      check("t1_done_pulse_width", {31'b0, done8}, 0);
      check("t1_sum_held", {23'b0, res_s}, 0);
      launch(8'hFF, 8'h01, 1'b0, 1);
      wait_done("t2", 8, 8);
      tick();
      launch(8'hA5, 8'h5A, 1'b1, 1);
      wait_done("t3a", 8, 8);
      launch(8'h3C, 8'h42, 1'b0, 1);
      check("t3_b2b_busy", {31'b0, busy8}, 1);
      check("t3_b2b_done_low", {31'b0, done8}, 0);
      a = 8'hEE;
      b = 8'hEE;
      wait_done("t3b", 8, 8);
      tick();
      launch(8'h10, 8'h20, 1'b0, 1);
      tick();
      tick();
      a      = 8'hFF;
      start8 = 1'b1;
      tick();
      start8 = 1'b0;
      wait_done("t4", 5, 5);
      pulses = 0;
      repeat (12) begin
         tick();
         if (done8) pulses++;
      end
      check("t4_extra_done", pulses, 0);
      check("t4_sum_stable", {23'b0, res_s}, 9'h030);
      launch(8'h80, 8'h80, 1'b0, 0);
      tick();
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t5_busy", {31'b0, busy8}, 0);
      check("t5_done", {31'b0, done8}, 0);
      check("t5_sum", {24'b0, sum8}, 0);
      check("t5_cout", {31'b0, cout8}, 0);
      pulses = 0;
      repeat (12) begin
         tick();
         if (done8) pulses++;
      end
      check("t5_no_done", pulses, 0);
      launch(8'h12, 8'h34, 1'b1, 1);
      wait_done("t5_restart", 8, 8);
      tick();
      sel = 1'b1;
      for (int i = 0; i < 128; i++) begin
         launch({5'b0, 3'(i)}, {5'b0, 3'(i >> 3)}, 1'(i >> 6), 1);
         wait_done($sformatf("t6_%0d", i), 3, 3);
         tick();
      end
      check("final_queue_empty", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
